// File: rtl/nes_joypad_serializer.sv
// -----------------------------------------------------------------------------
// nes_joypad_serializer
//
// Emulates the serial side of NES controller ports. A level strobe latches the
// parallel pad state into per-port shift registers; each high-to-low transition
// of a port's read clock shifts that port's registers by one bit. With
// four_score=1 the d0 stream is 24 bits long: primary pad, secondary pad, then
// a signature byte that identifies the Four Score adapter.
//
// Parameters
//   NUM_PORTS : number of serial controller ports (1..4)
//   FILL      : bit shifted into d0 after its stream is exhausted
//   SIG0      : Four Score signature byte for port 0, LSB first
//   SIG1      : Four Score signature byte for port 1 (ports 2/3 use 8'h00)
//
// Ports
//   clk        : system clock, the only clock
//   reset      : synchronous active-high reset
//   strobe     : level latch request; reloads every port every cycle while 1
//   port_clk   : per-port read clock; a read is its high-to-low transition
//   four_score : 1 selects the 24-bit Four Score d0 stream at reload
//   pad_in     : 2*NUM_PORTS pad bytes, player p at [8p+7:8p], bit0 = A;
//                players NUM_PORTS.. are the secondary pads of each port
//   aux_in     : per port i, d3 byte at [16i+7:16i], d4 byte at [16i+15:16i+8]
//   port_d0    : current serial d0 bit per port
//   port_d3    : current d3 lane bit per port
//   port_d4    : current d4 lane bit per port
//   rd_count   : per-port reads since last latch, 5 bits each, saturating at 31
// -----------------------------------------------------------------------------
module nes_joypad_serializer #(
    parameter int          NUM_PORTS = 2,
    parameter logic        FILL      = 1'b0,
    parameter logic [7:0]  SIG0      = 8'h08,
    parameter logic [7:0]  SIG1      = 8'h04
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    strobe,
    input  logic [NUM_PORTS-1:0]    port_clk,
    input  logic                    four_score,
    input  logic [16*NUM_PORTS-1:0] pad_in,
    input  logic [16*NUM_PORTS-1:0] aux_in,
    output logic [NUM_PORTS-1:0]    port_d0,
    output logic [NUM_PORTS-1:0]    port_d3,
    output logic [NUM_PORTS-1:0]    port_d4,
    output logic [5*NUM_PORTS-1:0]  rd_count
);

    localparam logic [4:0] CNT_MAX = 5'd31;

    // Signature byte appended after the two pad bytes in Four Score mode.
    function automatic logic [7:0] signature(input int port);
        case (port)
            0:       return SIG0;
            1:       return SIG1;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [23:0] d0_q;
        logic [7:0]  d3_q;
        logic [7:0]  d4_q;
        logic [4:0]  cnt_q;
        logic        clk_q;   // port_clk as seen on the previous cycle
        logic        read;
        logic [7:0]  primary;
        logic [7:0]  secondary;

        assign primary   = pad_in[8*i +: 8];
        assign secondary = pad_in[8*(i+NUM_PORTS) +: 8];

        // Falling edge of the port read clock. Strobe masks it so that a
        // read coinciding with a reload is discarded rather than applied to
        // the freshly loaded data.
        assign read = clk_q & ~port_clk[i] & ~strobe;

        // NOTE: all state here is sequential, so every assignment in this
        // block is non-blocking; the registers then all see pre-edge values.
        always_ff @(posedge clk) begin
            if (reset) begin
                d0_q  <= '0;
                d3_q  <= '0;
                d4_q  <= '0;
                cnt_q <= '0;
                clk_q <= 1'b0;
            end else begin
                // Tracked every cycle, strobe or not, so an edge that spans
                // the strobe release is seen exactly once.
                clk_q <= port_clk[i];
                if (strobe) begin
                    if (four_score) begin
                        d0_q <= {signature(i), secondary, primary};
                    end else begin
                        d0_q <= {{16{FILL}}, primary};
                    end
                    d3_q  <= aux_in[16*i +: 8];
                    d4_q  <= aux_in[16*i+8 +: 8];
                    cnt_q <= '0;
                end else if (read) begin
                    d0_q <= {FILL, d0_q[23:1]};
                    d3_q <= {1'b0, d3_q[7:1]};
                    d4_q <= {1'b0, d4_q[7:1]};
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
            end
        end

        // Outputs come straight from register bit 0; no input reaches them
        // combinationally.
        assign port_d0[i]          = d0_q[0];
        assign port_d3[i]          = d3_q[0];
        assign port_d4[i]          = d4_q[0];
        assign rd_count[5*i +: 5]  = cnt_q;
    end

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// -----------------------------------------------------------------------------
// tb_nes_joypad_serializer
//
// Directed scenarios with constant expectations, followed by a randomized run
// compared every cycle against a stream-index reference model: each port keeps
// the latched stream as a plain vector plus a count of reads, and the expected
// output bit is simply the stream element at that read index.
// -----------------------------------------------------------------------------
module tb_nes_joypad_serializer;

    localparam int         NP     = 2;
    localparam logic       FILL_B = 1'b0;
    localparam logic [7:0] SIG_0  = 8'h08;
    localparam logic [7:0] SIG_1  = 8'h04;

    logic              clk = 1'b0;
    logic              reset;
    logic              strobe;
    logic [NP-1:0]     port_clk;
    logic              four_score;
    logic [16*NP-1:0]  pad_in;
    logic [16*NP-1:0]  aux_in;
    logic [NP-1:0]     port_d0;
    logic [NP-1:0]     port_d3;
    logic [NP-1:0]     port_d4;
    logic [5*NP-1:0]   rd_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [23:0] m_stream [NP];
    logic [7:0]  m_a3     [NP];
    logic [7:0]  m_a4     [NP];
    int          m_n      [NP];
    logic        m_prev   [NP];

    nes_joypad_serializer #(
        .NUM_PORTS (NP),
        .FILL      (FILL_B),
        .SIG0      (SIG_0),
        .SIG1      (SIG_1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strobe     (strobe),
        .port_clk   (port_clk),
        .four_score (four_score),
        .pad_in     (pad_in),
        .aux_in     (aux_in),
        .port_d0    (port_d0),
        .port_d3    (port_d3),
        .port_d4    (port_d4),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sig_of(input int p);
        return (p == 0) ? SIG_0 : (p == 1) ? SIG_1 : 8'h00;
    endfunction

    function automatic logic exp_d0(input int p);
        return (m_n[p] < 24) ? m_stream[p][m_n[p]] : FILL_B;
    endfunction

    function automatic logic exp_d3(input int p);
        return (m_n[p] < 8) ? m_a3[p][m_n[p]] : 1'b0;
    endfunction

    function automatic logic exp_d4(input int p);
        return (m_n[p] < 8) ? m_a4[p][m_n[p]] : 1'b0;
    endfunction

    function automatic logic [4:0] exp_rd(input int p);
        return (m_n[p] > 31) ? 5'd31 : 5'(m_n[p]);
    endfunction

    function automatic logic [4:0] rd_of(input int p);
        return rd_count[5*p +: 5];
    endfunction

    // One clock edge: the model applies the rules to the inputs present at
    // the edge, then outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (reset) begin
                m_stream[p] = '0;
                m_a3[p]     = '0;
                m_a4[p]     = '0;
                m_n[p]      = 0;
                m_prev[p]   = 1'b0;
            end else begin
                if (strobe) begin
                    m_stream[p] = four_score
                        ? {sig_of(p), pad_in[8*(p+NP) +: 8], pad_in[8*p +: 8]}
                        : {{16{FILL_B}}, pad_in[8*p +: 8]};
                    m_a3[p] = aux_in[16*p +: 8];
                    m_a4[p] = aux_in[16*p+8 +: 8];
                    m_n[p]  = 0;
                end else if (m_prev[p] && !port_clk[p]) begin
                    m_n[p]++;
                end
                m_prev[p] = port_clk[p];
            end
        end
        #1;
    endtask

    task automatic do_read(input int p);
        port_clk[p] = 1'b1;
        tick();
        port_clk[p] = 1'b0;
        tick();
    endtask

    task automatic latch();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (port_d0 !== '0 || port_d3 !== '0 || port_d4 !== '0 || rd_count !== '0) begin
            failures++;
            $display("FAIL reset_state: d0=%b d3=%b d4=%b rd=%h, required all 0",
                     port_d0, port_d3, port_d4, rd_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_stream();
        logic seq [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FILL_B, FILL_B};
        four_score = 1'b0;
        pad_in = '0;
        pad_in[7:0]  = 8'hA5;
        pad_in[15:8] = 8'h5B;
        latch();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (port_d0[0] !== seq[i]) begin
                failures++;
                $display("FAIL basic_d0[%0d]: got %b required %b", i, port_d0[0], seq[i]);
            end
            do_read(0);
        end
        checks++;
        if (rd_of(0) !== 5'd10) begin
            failures++;
            $display("FAIL basic_rd_count0: got %0d required 10", rd_of(0));
        end
        checks++;
        if (rd_of(1) !== 5'd0 || port_d0[1] !== 1'b1) begin
            failures++;
            $display("FAIL basic_port1_untouched: rd=%0d d0=%b required rd=0 d0=1",
                     rd_of(1), port_d0[1]);
        end
    endtask

    task automatic test_four_score();
        logic [23:0] s0;
        logic [23:0] s1;
        four_score = 1'b1;
        pad_in = '0;
        pad_in[7:0]   = 8'h01;
        pad_in[23:16] = 8'h80;
        s0 = {SIG_0, 8'h80, 8'h01};
        s1 = {SIG_1, 8'h00, 8'h00};
        latch();
        for (int i = 0; i < 26; i++) begin
            checks++;
            if (port_d0[0] !== ((i < 24) ? s0[i] : FILL_B)) begin
                failures++;
                $display("FAIL fs_port0[%0d]: got %b required %b", i, port_d0[0],
                         (i < 24) ? s0[i] : FILL_B);
            end
            do_read(0);
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (port_d0[1] !== s1[i]) begin
                failures++;
                $display("FAIL fs_port1[%0d]: got %b required %b", i, port_d0[1], s1[i]);
            end
            do_read(1);
        end
        four_score = 1'b0;
    endtask

    task automatic test_strobe_hold();
        pad_in[15:8] = 8'h00;
        strobe = 1'b1;
        tick();
        checks++;
        if (port_d0[1] !== 1'b0) begin
            failures++;
            $display("FAIL hold_before: got %b required 0", port_d0[1]);
        end
        pad_in[15:8] = 8'hFF;
        port_clk[1] = 1'b1;
        #1;
        checks++;
        if (port_d0[1] !== 1'b0) begin
            failures++;
            $display("FAIL hold_latency: got %b required 0", port_d0[1]);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            port_clk[1] = ~port_clk[1];
            tick();
            checks++;
            if (port_d0[1] !== 1'b1 || rd_of(1) !== 5'd0) begin
                failures++;
                $display("FAIL hold_follow[%0d]: d0=%b rd=%0d required d0=1 rd=0",
                         i, port_d0[1], rd_of(1));
            end
        end
        strobe = 1'b0;
        port_clk[1] = 1'b0;
        tick();
    endtask

    task automatic test_strobe_collision();
        pad_in[7:0] = 8'h02;
        latch();
        port_clk[0] = 1'b1;
        tick();
        strobe = 1'b1;
        port_clk[0] = 1'b0;
        tick();
        strobe = 1'b0;
        tick();
        checks++;
        if (port_d0[0] !== 1'b0 || rd_of(0) !== 5'd0) begin
            failures++;
            $display("FAIL collision: d0=%b rd=%0d required d0=0 rd=0", port_d0[0], rd_of(0));
        end
    endtask

    task automatic test_aux_saturate();
        aux_in = '0;
        aux_in[23:16] = 8'h03;
        aux_in[31:24] = 8'h80;
        latch();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (port_d3[1] !== ((i < 2) ? 1'b1 : 1'b0) ||
                port_d4[1] !== ((i == 7) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL aux[%0d]: d3=%b d4=%b required d3=%b d4=%b", i,
                         port_d3[1], port_d4[1], (i < 2) ? 1'b1 : 1'b0,
                         (i == 7) ? 1'b1 : 1'b0);
            end
            do_read(1);
        end
        for (int i = 0; i < 40; i++) do_read(1);
        checks++;
        if (rd_of(1) !== 5'd31) begin
            failures++;
            $display("FAIL rd_saturate: got %0d required 31", rd_of(1));
        end
    endtask

    task automatic test_reset_midstream();
        pad_in = '1;
        aux_in = '1;
        latch();
        for (int i = 0; i < 5; i++) do_read(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (port_d0 !== '0 || port_d3 !== '0 || port_d4 !== '0 || rd_count !== '0) begin
            failures++;
            $display("FAIL reset_mid: d0=%b d3=%b d4=%b rd=%h required all 0",
                     port_d0, port_d3, port_d4, rd_count);
        end
        do_read(0);
        checks++;
        if (port_d0[0] !== 1'b0 || port_d3[0] !== 1'b0 || rd_of(0) !== 5'd1) begin
            failures++;
            $display("FAIL reset_then_read: d0=%b d3=%b rd=%0d required 0 0 1",
                     port_d0[0], port_d3[0], rd_of(0));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            strobe     = ($urandom_range(0, 39) == 0);
            port_clk   = NP'($urandom);
            if ($urandom_range(0, 15) == 0) four_score = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                pad_in = {$urandom, $urandom};
                aux_in = {$urandom, $urandom};
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (port_d0[p] !== exp_d0(p) || port_d3[p] !== exp_d3(p) ||
                    port_d4[p] !== exp_d4(p) || rd_of(p) !== exp_rd(p)) begin
                    failures++;
                    $display("FAIL random c%0d p%0d: d0/d3/d4/rd=%b%b%b/%0d required %b%b%b/%0d",
                             c, p, port_d0[p], port_d3[p], port_d4[p], rd_of(p),
                             exp_d0(p), exp_d3(p), exp_d4(p), exp_rd(p));
                end
            end
        end
        reset  = 1'b0;
        strobe = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        strobe     = 1'b0;
        port_clk   = '0;
        four_score = 1'b0;
        pad_in     = '0;
        aux_in     = '0;
        for (int p = 0; p < NP; p++) begin
            m_stream[p] = '0;
            m_a3[p]     = '0;
            m_a4[p]     = '0;
            m_n[p]      = 0;
            m_prev[p]   = 1'b0;
        end
        #2;
        test_reset();
        test_basic_stream();
        test_four_score();
        test_strobe_hold();
        test_strobe_collision();
        test_aux_saturate();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
